// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter and fetch-redirect stage.
// Holds the architectural PC and advances it by PC_INC each cycle. A taken
// branch or register jump loads the target and asserts flush for
// FLUSH_CYCLES unstalled cycles. halt_req parks the sequencer until reset.
//
// Ports:
//   clk         system clock, all state updates on the rising edge
//   rst         synchronous, active-high reset
//   stall       hold pc and freeze the flush countdown
//   br_taken    branch taken, redirect to br_target
//   br_target   resolved branch target
//   jr          register-indirect jump, redirect to jr_target (wins over br_taken)
//   jr_target   register jump target
//   halt_req    halt instruction decoded
//   pc          current fetch address (registered)
//   link_addr   pc + PC_INC (combinational)
//   flush       squash in-flight fetch/decode entries
//   instr_valid instruction at pc is architecturally valid
//   halted      sequencer stopped
//   misalign    sticky, set when a redirect target is not a multiple of PC_INC
module pc_sequencer #(
  parameter int unsigned ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned PC_INC       = 4,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              jr,
  input  logic [ADDR_W-1:0] jr_target,
  input  logic              halt_req,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] link_addr,
  output logic              flush,
  output logic              instr_valid,
  output logic              halted,
  output logic              misalign
);

  localparam logic [ADDR_W-1:0] INC       = ADDR_W'(PC_INC);
  localparam logic [3:0]        FLUSH_LEN = 4'(FLUSH_CYCLES);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] pc_n;
  logic [3:0]        cnt, cnt_n;
  logic              misalign_n;
  logic [ADDR_W-1:0] redirect_target;
  logic              redirect;

  // jr has priority over br_taken when both arrive together.
  assign redirect        = jr | br_taken;
  assign redirect_target = jr ? jr_target : br_target;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      pc       <= RESET_PC;
      cnt      <= '0;
      misalign <= 1'b0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      cnt      <= cnt_n;
      misalign <= misalign_n;
    end
  end

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    cnt_n      = cnt;
    misalign_n = misalign;
    unique case (state)
      RUN: begin
        if (halt_req) begin
          state_n = HALT;
        end else if (redirect) begin
          state_n = FLUSH;
          pc_n    = redirect_target;
          cnt_n   = FLUSH_LEN;
          if ((redirect_target % INC) != '0) misalign_n = 1'b1;
        end else if (!stall) begin
          pc_n = pc + INC;
        end
      end
      FLUSH: begin
        // Redirects and halts seen here come from squashed instructions.
        if (!stall) begin
          pc_n = pc + INC;
          if (cnt <= 4'd1) begin
            state_n = RUN;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt - 4'd1;
          end
        end
      end
      HALT: begin
        state_n = HALT;
      end
      default: begin
        state_n = RUN;
      end
    endcase
  end

  assign link_addr   = pc + INC;
  assign flush       = (state == FLUSH);
  assign instr_valid = (state == RUN);
  assign halted      = (state == HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst, stall, br_taken, jr, halt_req;
  logic [31:0] br_target, jr_target;
  logic [31:0] pc, link_addr;
  logic        flush, instr_valid, halted, misalign;
  logic [3:0]  flags;

  int checks   = 0;
  int failures = 0;

  // Reference model: pc, remaining flush cycles, halt flag, sticky misalign.
  logic [31:0] m_pc;
  int          m_flush_left;
  bit          m_halted;
  bit          m_mis;

  always #5 clk = ~clk;

  assign flags = {flush, instr_valid, halted, misalign};

  pc_sequencer #(
    .ADDR_W(32),
    .RESET_PC(32'h0),
    .PC_INC(4),
    .FLUSH_CYCLES(2)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .br_taken(br_taken), .br_target(br_target),
    .jr(jr), .jr_target(jr_target), .halt_req(halt_req),
    .pc(pc), .link_addr(link_addr), .flush(flush),
    .instr_valid(instr_valid), .halted(halted), .misalign(misalign)
  );

  task automatic model_step();
    if (rst) begin
      m_pc = 32'h0; m_flush_left = 0; m_halted = 0; m_mis = 0;
    end else if (m_halted) begin
      // parked until reset
    end else if (m_flush_left > 0) begin
      if (!stall) begin
        m_flush_left--;
        m_pc = m_pc + 32'd4;
      end
    end else if (halt_req) begin
      m_halted = 1;
    end else if (jr || br_taken) begin
      m_pc = jr ? jr_target : br_target;
      m_flush_left = 2;
      if (m_pc % 4 != 0) m_mis = 1;
    end else if (!stall) begin
      m_pc = m_pc + 32'd4;
    end
  endtask

  // Inputs change 1 time unit after a rising edge; the model sees the same
  // values the DUT samples on the next edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; stall = 0; br_taken = 0; jr = 0; halt_req = 0;
    br_target = '0; jr_target = '0;
  endtask

  function automatic logic [3:0] m_flags();
    return {m_flush_left > 0, !m_halted && m_flush_left == 0, m_halted, m_mis};
  endfunction

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    logic [31:0] exp_pc;
    do_reset();
    for (int unsigned i = 0; i < 4; i++) begin
      exp_pc = 32'(i * 4);
      checks++;
      if ({pc, flags} !== {exp_pc, 4'b0100}) begin
        failures++;
        $display("FAIL reset_seq[%0d] pc=%h flags=%b expected pc=%h flags=0100", i, pc, flags, exp_pc);
      end
      if (i < 3) tick();
    end
  endtask

  task automatic test_branch();
    logic [31:0] exp_pc [3] = '{32'h40, 32'h44, 32'h48};
    logic [3:0]  exp_fl [3] = '{4'b1000, 4'b1000, 4'b0100};
    tick();  // 0x0C -> 0x10
    checks++;
    if (pc !== 32'h10) begin
      failures++;
      $display("FAIL branch_setup pc=%h expected 00000010", pc);
    end
    br_taken = 1; br_target = 32'h40;
    tick();
    br_taken = 0;
    for (int unsigned i = 0; i < 3; i++) begin
      checks++;
      if ({pc, flags} !== {exp_pc[i], exp_fl[i]}) begin
        failures++;
        $display("FAIL branch[%0d] pc=%h flags=%b expected pc=%h flags=%b", i, pc, flags, exp_pc[i], exp_fl[i]);
      end
      if (i < 2) tick();
    end
  endtask

  task automatic test_jr_priority();
    jr = 1; jr_target = 32'h100; br_taken = 1; br_target = 32'h200;
    tick();
    jr = 0;
    checks++;
    if ({pc, flags} !== {32'h100, 4'b1000}) begin
      failures++;
      $display("FAIL jr_priority pc=%h flags=%b expected pc=00000100 flags=1000", pc, flags);
    end
    br_target = 32'h300;  // br_taken still high: squashed branch inside flush
    tick();
    br_taken = 0;
    checks++;
    if ({pc, flags} !== {32'h104, 4'b1000}) begin
      failures++;
      $display("FAIL flush_ignores_br pc=%h flags=%b expected pc=00000104 flags=1000", pc, flags);
    end
    tick();
    checks++;
    if ({pc, flags} !== {32'h108, 4'b0100}) begin
      failures++;
      $display("FAIL jr_flush_end pc=%h flags=%b expected pc=00000108 flags=0100", pc, flags);
    end
  endtask

  task automatic test_stall_flush();
    br_taken = 1; br_target = 32'h80; stall = 1;  // redirect overrides stall
    tick();
    br_taken = 0;
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({pc, flags} !== {32'h80, 4'b1000}) begin
        failures++;
        $display("FAIL stall_flush[%0d] pc=%h flags=%b expected pc=00000080 flags=1000", i, pc, flags);
      end
    end
    stall = 0;
    tick();
    checks++;
    if ({pc, flags} !== {32'h84, 4'b1000}) begin
      failures++;
      $display("FAIL stall_release1 pc=%h flags=%b expected pc=00000084 flags=1000", pc, flags);
    end
    tick();
    checks++;
    if ({pc, flags} !== {32'h88, 4'b0100}) begin
      failures++;
      $display("FAIL stall_release2 pc=%h flags=%b expected pc=00000088 flags=0100", pc, flags);
    end
  endtask

  task automatic test_misalign();
    br_taken = 1; br_target = 32'h42;
    tick();
    br_taken = 0;
    checks++;
    if ({pc, flags} !== {32'h42, 4'b1001}) begin
      failures++;
      $display("FAIL misalign_set pc=%h flags=%b expected pc=00000042 flags=1001", pc, flags);
    end
    tick(); tick();
    jr = 1; jr_target = 32'h50;
    tick();
    jr = 0;
    checks++;
    if ({pc, flags} !== {32'h50, 4'b1001}) begin
      failures++;
      $display("FAIL misalign_sticky pc=%h flags=%b expected pc=00000050 flags=1001", pc, flags);
    end
    do_reset();
    checks++;
    if ({pc, flags} !== {32'h0, 4'b0100}) begin
      failures++;
      $display("FAIL misalign_clear pc=%h flags=%b expected pc=00000000 flags=0100", pc, flags);
    end
  endtask

  task automatic test_halt();
    repeat (8) tick();
    halt_req = 1;
    tick();
    halt_req = 0;
    for (int unsigned i = 0; i < 5; i++) begin
      checks++;
      if ({pc, flags} !== {32'h20, 4'b0010}) begin
        failures++;
        $display("FAIL halt_hold[%0d] pc=%h flags=%b expected pc=00000020 flags=0010", i, pc, flags);
      end
      br_taken = 1; br_target = 32'h400; jr = i[0]; jr_target = 32'h500; stall = i[1];
      halt_req = i[0];
      tick();
    end
    idle_inputs();
    do_reset();
    checks++;
    if ({pc, flags} !== {32'h0, 4'b0100}) begin
      failures++;
      $display("FAIL halt_reset pc=%h flags=%b expected pc=00000000 flags=0100", pc, flags);
    end
  endtask

  task automatic test_wrap();
    jr = 1; jr_target = 32'hFFFF_FFF4;
    tick();
    jr = 0;
    tick(); tick();
    checks++;
    if ({pc, link_addr, flags} !== {32'hFFFF_FFFC, 32'h0, 4'b0100}) begin
      failures++;
      $display("FAIL wrap_top pc=%h link=%h flags=%b expected pc=fffffffc link=00000000 flags=0100", pc, link_addr, flags);
    end
    tick();
    checks++;
    if ({pc, link_addr} !== {32'h0, 32'h4}) begin
      failures++;
      $display("FAIL wrap pc=%h link=%h expected pc=00000000 link=00000004", pc, link_addr);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int unsigned i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 199) == 0);
      halt_req  = ($urandom_range(0, 99) == 0);
      jr        = ($urandom_range(0, 11) == 0);
      br_taken  = ($urandom_range(0, 5) == 0);
      stall     = ($urandom_range(0, 3) == 0);
      br_target = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      jr_target = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      tick();
      checks++;
      if ({pc, link_addr, flags} !== {m_pc, m_pc + 32'd4, m_flags()}) begin
        failures++;
        $display("FAIL random[%0d] pc=%h link=%h flags=%b expected pc=%h link=%h flags=%b",
                 i, pc, link_addr, flags, m_pc, m_pc + 32'd4, m_flags());
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    #1;
    test_reset();
    test_branch();
    test_jr_priority();
    test_stall_flush();
    test_misalign();
    test_halt();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter and fetch-redirect stage that directly consumes the branch-decision output (taken/not-taken) and the resolved branch target.
- Holds the architectural PC and advances it sequentially.
- On a taken branch or register jump, loads the target and raises a flush to squash in-flight wrong-path instructions.
- Supports pipeline stall and a terminal halt state.

Parameters:
- ADDR_W, 32, width of PC and target addresses
- RESET_PC, 0, PC value loaded on reset
- PC_INC, 4, sequential increment (bytes per instruction)
- FLUSH_CYCLES, 2, cycles flush stays asserted after a redirect (range 1..15)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold PC and freeze flush countdown this cycle
- br_taken  in  1  branch-decision result; redirect to br_target
- br_target  in  ADDR_W  resolved branch target
- jr  in  1  register-indirect jump; redirect to jr_target
- jr_target  in  ADDR_W  register jump target
- halt_req  in  1  halt instruction decoded
- pc  out  ADDR_W  current fetch address (registered)
- link_addr  out  ADDR_W  pc + PC_INC (combinational, for call/link write-back)
- flush  out  1  squash in-flight fetch/decode entries
- instr_valid  out  1  fetched instruction at pc is architecturally valid
- halted  out  1  sequencer stopped
- misalign  out  1  sticky: a redirect target had nonzero low bits (target mod PC_INC != 0)

Behaviour:
- States: RUN, FLUSH, HALT. Reset → RUN, pc=RESET_PC, flush=0, halted=0, misalign=0, instr_valid=1 from first cycle after reset; flush counter=0.
- Event priority each edge: rst > halt_req > jr > br_taken > stall > sequential increment.
- RUN, no event, stall=0: pc <= pc + PC_INC, wraps modulo 2^ADDR_W (all-ones region wraps to 0, no error).
- RUN, stall=1, no redirect/halt: pc holds.
- RUN, jr=1: pc <= jr_target; enter FLUSH, counter <= FLUSH_CYCLES. jr wins over simultaneous br_taken.
- RUN, br_taken=1 (jr=0): pc <= br_target; enter FLUSH, counter <= FLUSH_CYCLES.
- Redirects are taken even when stall=1; the redirect overrides the stall.
- Redirect target alignment: low bits are loaded unmodified. misalign is set if target mod PC_INC != 0, and clears only on rst.
- FLUSH: flush=1 and instr_valid=0 (Moore outputs from state).
  - Each non-stalled cycle, counter decrements and pc <= pc + PC_INC.
  - Stall freezes both the counter and pc.
  - When counter reaches 1 and stall=0, next state is RUN.
  - Flush therefore lasts exactly FLUSH_CYCLES non-stalled cycles.
- FLUSH: br_taken and jr are ignored, since they come from squashed instructions. halt_req is also ignored for the same reason.
- halt_req in RUN (regardless of stall/redirect): enter HALT, pc holds at current value. halted=1, instr_valid=0, flush=0.
- HALT: all inputs ignored; exit only via rst.
- rst asserted mid-FLUSH or in HALT: next cycle is RUN with pc=RESET_PC, counter cleared, misalign cleared.
- link_addr is always pc + PC_INC with wrap, independent of state.

Test Plan:
- Reset then 3 idle cycles (PC_INC=4, RESET_PC=0) → pc sequence 0,4,8,12; flush=0, instr_valid=1, halted=0.
- At pc=0x10, br_taken=1, br_target=0x40 → next pc=0x40, flush=1 and instr_valid=0 for exactly 2 cycles (pc 0x40, 0x44), then RUN at pc=0x48 with flush=0.
- jr=1 (jr_target=0x100) and br_taken=1 (br_target=0x200) in the same cycle → pc=0x100. A br_taken pulse during the following flush is ignored and pc continues 0x104.
- Redirect to 0x80, then stall=1 for 3 cycles during FLUSH → pc frozen at 0x80 and flush held. Once stall releases, flush lasts 2 more cycles.
- Redirect to 0x42 → misalign=1, pc=0x42. Misalign remains 1 after a later redirect to 0x50, and clears only on rst.
- halt_req at pc=0x20 → halted=1, pc stays 0x20 despite br_taken/stall/jr for 5 cycles. Asserting rst → pc=0, halted=0.
- pc=0xFFFFFFFC, idle → pc wraps to 0x0 and link_addr=0x4.
